// File: rtl/key_filter4_if.sv
// Key conditioner bus: raw active-low key pins in, debounced levels,
// press pulses and encoded key index out.
interface key_filter4_if;
    logic [3:0] key_in;
    logic [3:0] key_state;
    logic [3:0] key_flag;
    logic [1:0] key_code;
    logic       key_valid;

    // Board/stimulus side: drives the pins, consumes key events
    modport master (
        output key_in,
        input  key_state, key_flag, key_code, key_valid
    );

    // Conditioner side
    modport slave (
        input  key_in,
        output key_state, key_flag, key_code, key_valid
    );
endinterface

// File: rtl/key_filter4.sv
// key_filter4: four independent key channels, each synchronised and
// debounced, plus a registered press pulse per key and a lowest-index
// encoded key code with a one-cycle valid strobe.

// One key channel: 2-flop synchroniser, debounce counter and state bit.
// o_set is the combinational "goes pressed on this edge" condition so the
// top can register flags/valid/code on the same edge that r_st updates.
module key_filter4_lane #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_n,
    output logic o_state,
    output logic o_set
);
    logic [1:0]  r_sync;
    logic [19:0] r_cnt;
    logic        r_st;
    logic        w_press;
    logic        w_diff;
    logic        w_full;

    assign w_press = ~r_sync[1];
    assign w_diff  = (w_press != r_st);
    assign w_full  = (r_cnt == CNT_MAX);
    assign o_set   = w_diff & w_full & w_press;
    assign o_state = r_st;

    // Two-flop synchroniser; resets to the released level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_sync <= 2'b11;
        else            r_sync <= {r_sync[0], i_key_n};
    end

    // Debounce: count consecutive samples disagreeing with r_st; any
    // agreeing sample restarts the window, a full window flips the state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
            r_st  <= 1'b0;
        end else if (!w_diff) begin
            r_cnt <= '0;
        end else if (w_full) begin
            r_st  <= w_press;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 20'd1;
        end
    end
endmodule

module key_filter4 #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    key_filter4_if.slave kif
);
    localparam int NUM_KEYS = 4;

    logic [NUM_KEYS-1:0] w_state;
    logic [NUM_KEYS-1:0] w_set;
    logic [1:0]          w_code;
    logic [NUM_KEYS-1:0] r_flag;
    logic                r_valid;
    logic [1:0]          r_code;

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_lane
            key_filter4_lane #(.CNT_MAX(CNT_MAX)) u_lane (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .i_key_n   (kif.key_in[g]),
                .o_state   (w_state[g]),
                .o_set     (w_set[g])
            );
        end
    endgenerate

    // Lowest index among keys going pressed this edge wins the code
    always_comb begin
        w_code = 2'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_set[i]) w_code = 2'(i);
        end
    end

    // Press event registers; code holds its last value between presses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_flag  <= '0;
            r_valid <= 1'b0;
            r_code  <= 2'd0;
        end else begin
            r_flag  <= w_set;
            r_valid <= |w_set;
            if (|w_set) r_code <= w_code;
        end
    end

    assign kif.key_state = w_state;
    assign kif.key_flag  = r_flag;
    assign kif.key_valid = r_valid;
    assign kif.key_code  = r_code;
endmodule
